bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter built from a chain of DIGITS shift-left-by-1 BCD digit cells (double-dabble, one bit per clock). The binary operand is shifted in MSB first. Every digit computes (2*d + carry_in) mod 10 and passes carry_out = (d >= 5) to the next digit. The block sits between binary counters/ALU results and display/serial-out logic, with a start/done handshake and a sticky overflow flag when the value exceeds DIGITS decimal digits.

Parameters:
BIN_W, 16, width of binary input operand (>= 1)
DIGITS, 5, number of BCD output digits (>= 1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
START  input  1  request conversion; sampled only when idle
BIN  input  BIN_W  unsigned operand; captured on accepted START
BUSY  output  1  high while conversion in progress
DONE  output  1  one-cycle pulse: BCD/OVERFLOW updated
BCD  output  4*DIGITS  result; digit i at bits [4i+3:4i], digit 0 = units
OVERFLOW  output  1  result valid only modulo 10^DIGITS (BIN >= 10^DIGITS)

Behaviour:
- Reset (async, RST high): state IDLE; BUSY=0, DONE=0, BCD=0, OVERFLOW=0; internal shift reg, accumulator and bit counter cleared.
- States: IDLE, SHIFT. No other states. Unused encodings return to IDLE.
- IDLE, START=1 at an edge: shift reg <= BIN, accumulator digits <= 0, counter <= 0, sticky ovf <= 0, state <= SHIFT, BUSY <= 1. START=0: remain IDLE.
- SHIFT, each edge: bit b = shift reg MSB; shift reg <<= 1.
  - Digit 0 gets carry_in = b. Digit i gets carry_in = carry_out of digit i-1.
  - Each digit: d_next = (d>=5) ? 2d-10+cin : 2d+cin. carry_out = (d>=5).
  - Digit value > 9 (corrupt state): d_next = {3'd7,cin}, carry_out = 1, which forces the overflow flag.
  - sticky ovf |= carry_out of digit DIGITS-1.
  - counter increments.
- On the SHIFT edge processing bit index 0 (the BIN_W-th shift edge):
  - BCD <= new accumulator; OVERFLOW <= new sticky ovf.
  - DONE <= 1; BUSY <= 0; state <= IDLE.
- DONE is high for exactly one cycle, then 0.
- Latency: START accepted at edge E. BUSY is high for BIN_W cycles after E. DONE is high in the cycle following edge E+BIN_W.
- BCD/OVERFLOW hold the last result until the next DONE. Intermediate accumulator values are never visible on BCD.
- START while BUSY: ignored; operand not recaptured; no queueing.
- START in the DONE cycle: accepted, since the block is IDLE. Back-to-back conversions achieve one result per BIN_W+1 cycles.
- BIN changes after acceptance: no effect on the in-flight conversion.
- Reset mid-conversion: immediate abort to reset values. No DONE is produced for the aborted operand.
- DIGITS large enough (10^DIGITS > 2^BIN_W - 1): OVERFLOW is structurally always 0.

Test Plan:
- BIN_W=16, DIGITS=5, BIN=65535, START pulse -> BUSY high 16 cycles; DONE one cycle after the 16th shift edge; BCD=20'h65535, OVERFLOW=0.
- BIN_W=16, DIGITS=4: BIN=9999 -> BCD=16'h9999, OVERFLOW=0. BIN=10000 -> BCD=16'h0000, OVERFLOW=1. BIN=12345 -> BCD=16'h2345, OVERFLOW=1.
- BIN=0, then BIN=1, then BIN=59 (DIGITS=5) -> BCD 20'h00000, 20'h00001, 20'h00059 respectively; OVERFLOW=0 each.
- START held high continuously with BIN=100 then BIN=250 applied in the DONE cycle -> successive DONE pulses 17 cycles apart; results 20'h00100 then 20'h00250. Pulses of START while BUSY produce no extra DONE.
- Assert RST for one cycle at shift 8 of a 16-bit conversion -> BUSY, DONE, BCD and OVERFLOW all 0 immediately; no DONE follows. A following conversion of 4321 gives 20'h04321.
- Random sweep: BIN_W=8/DIGITS=2 and BIN_W=12/DIGITS=4, all operand values -> BCD equals decimal value mod 10^DIGITS; OVERFLOW equals (value >= 10^DIGITS).

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/done request-response bundle for the sequential binary-to-BCD converter.
// The converter takes the slave side; the requester takes the master side.
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  START;
   logic [BIN_W-1:0]      BIN;
   logic                  BUSY;
   logic                  DONE;
   logic [4*DIGITS-1:0]   BCD;
   logic                  OVERFLOW;

   modport master (output START, BIN, input BUSY, DONE, BCD, OVERFLOW);
   modport slave  (input START, BIN, output BUSY, DONE, BCD, OVERFLOW);
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD converter: one operand bit per clock, MSB first,
// through a chain of DIGITS shift-left-by-1 BCD cells with a sticky overflow.

module bin2bcd_cell (
   input  logic [3:0] i_d,
   input  logic       i_cin,
   output logic [3:0] o_d,
   output logic       o_cout
);
   logic [4:0] w_dbl;
   logic [4:0] w_adj;

   assign w_dbl = {i_d, i_cin};
   assign w_adj = w_dbl - 5'd10;

   always_comb begin
      o_d    = w_dbl[3:0];
      o_cout = 1'b0;
      // A non-decimal digit can only come from corruption; push it out as overflow.
      if (i_d > 4'd9) begin
         o_d    = {3'd7, i_cin};
         o_cout = 1'b1;
      end else if (i_d >= 4'd5) begin
         o_d    = w_adj[3:0];
         o_cout = 1'b1;
      end
   end
endmodule

module bin2bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic           CLK,
   input  logic           RST,
   bin2bcd_seq_if.slave   bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t                r_state, w_state_nx;
   logic [BIN_W-1:0]      r_sr, w_sr_nx;
   logic [4*DIGITS-1:0]   r_acc, w_acc_nx;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
   logic                  r_ovf, w_ovf_nx;
   logic                  r_done, w_done_nx;
   logic [4*DIGITS-1:0]   r_bcd, w_bcd_nx;
   logic                  r_ovf_out, w_ovf_out_nx;

   logic [DIGITS:0]       w_carry;
   logic [4*DIGITS-1:0]   w_acc_shift;

   assign w_carry[0] = r_sr[BIN_W-1];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_dig
         bin2bcd_cell u_cell (
            .i_d    (r_acc[4*gi +: 4]),
            .i_cin  (w_carry[gi]),
            .o_d    (w_acc_shift[4*gi +: 4]),
            .o_cout (w_carry[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx   = r_state;
      w_sr_nx      = r_sr;
      w_acc_nx     = r_acc;
      w_cnt_nx     = r_cnt;
      w_ovf_nx     = r_ovf;
      w_done_nx    = 1'b0;
      w_bcd_nx     = r_bcd;
      w_ovf_out_nx = r_ovf_out;
      case (r_state)
         IDLE: begin
            if (bus.START) begin
               w_sr_nx    = bus.BIN;
               w_acc_nx   = '0;
               w_cnt_nx   = '0;
               w_ovf_nx   = 1'b0;
               w_state_nx = SHIFT;
            end
         end
         SHIFT: begin
            w_sr_nx  = r_sr << 1;
            w_acc_nx = w_acc_shift;
            w_cnt_nx = r_cnt + 1'b1;
            w_ovf_nx = r_ovf | w_carry[DIGITS];
            // Last bit: publish straight from the cell outputs so BCD never shows partials.
            if (r_cnt == CNT_W'(BIN_W - 1)) begin
               w_bcd_nx     = w_acc_shift;
               w_ovf_out_nx = r_ovf | w_carry[DIGITS];
               w_done_nx    = 1'b1;
               w_state_nx   = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sr      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
         r_bcd     <= '0;
         r_ovf_out <= 1'b0;
      end else begin
         r_sr      <= w_sr_nx;
         r_acc     <= w_acc_nx;
         r_cnt     <= w_cnt_nx;
         r_ovf     <= w_ovf_nx;
         r_done    <= w_done_nx;
         r_bcd     <= w_bcd_nx;
         r_ovf_out <= w_ovf_out_nx;
      end
   end

   assign bus.BUSY     = (r_state == SHIFT);
   assign bus.DONE     = r_done;
   assign bus.BCD      = r_bcd;
   assign bus.OVERFLOW = r_ovf_out;
endmodule
